led_pattern_classifier: RTL and testbench



---
 rtl/led_pattern_classifier.sv | 233 +++++++++++++++++++++++
 tb/tb_led_pattern_classifier.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : led_pattern_classifier
//  Purpose  : Two-stage checker that classifies 16-bit LED patterns, measures
//             motion against the previous sample and tracks class persistence.
//  Revision : 1.0  initial release
// ============================================================================
module led_pattern_classifier #(
    parameter int STABLE_LEN = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [15:0]      in_pattern,
    output logic             out_valid,
    output logic [2:0]       out_class,
    output logic [1:0]       out_motion,
    output logic [3:0]       out_pos,
    output logic             stable,
    output logic [CNT_W-1:0] change_count
);

    localparam logic [2:0] c_CLS_ZERO   = 3'd0;
    localparam logic [2:0] c_CLS_SINGLE = 3'd1;
    localparam logic [2:0] c_CLS_BAND   = 3'd2;
    localparam logic [2:0] c_CLS_ALT    = 3'd3;
    localparam logic [2:0] c_CLS_FULL   = 3'd4;
    localparam logic [2:0] c_CLS_OTHER  = 3'd5;

    localparam logic [1:0] c_MOT_HOLD = 2'd0;
    localparam logic [1:0] c_MOT_UP   = 2'd1;
    localparam logic [1:0] c_MOT_DOWN = 2'd2;
    localparam logic [1:0] c_MOT_JUMP = 2'd3;

    // Run counter saturates at STABLE_LEN, which never exceeds 255.
    localparam int         c_RUN_W  = 8;
    localparam logic [c_RUN_W-1:0] c_STABLE = c_RUN_W'(STABLE_LEN);
    localparam logic [c_RUN_W-1:0] c_RUN_ONE = c_RUN_W'(1);

    // Band of half-width d: ones from bit 7-d up to bit 8+d.
    function automatic logic [15:0] band_mask(input int d);
        logic [15:0] m;
        m = '0;
        for (int b = 0; b < 16; b++) begin
            if ((b >= 7 - d) && (b <= 8 + d)) begin
                m[b] = 1'b1;
            end
        end
        return m;
    endfunction

    // ------------------------------------------------------------------
    // Stage 1 combinational: shape features of the incoming pattern
    // ------------------------------------------------------------------
    logic [4:0] w_pop;
    logic [3:0] w_low;
    logic       w_band_hit;
    logic [3:0] w_band_d;
    logic [2:0] w_class;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < 16; i++) begin
            w_pop = w_pop + 5'(in_pattern[i]);
        end

        w_low = '0;
        for (int i = 15; i >= 0; i--) begin
            if (in_pattern[i]) begin
                w_low = 4'(i);
            end
        end

        w_band_hit = 1'b0;
        w_band_d   = '0;
        for (int d = 0; d < 7; d++) begin
            if (in_pattern == band_mask(d)) begin
                w_band_hit = 1'b1;
                w_band_d   = 4'(d);
            end
        end

        if (in_pattern == 16'h0000) begin
            w_class = c_CLS_ZERO;
        end else if (in_pattern == 16'hFFFF) begin
            w_class = c_CLS_FULL;
        end else if ((in_pattern == 16'hAAAA) || (in_pattern == 16'h5555)) begin
            w_class = c_CLS_ALT;
        end else if (w_pop == 5'd1) begin
            w_class = c_CLS_SINGLE;
        end else if (w_band_hit) begin
            w_class = c_CLS_BAND;
        end else begin
            w_class = c_CLS_OTHER;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic        r_s1_valid;
    logic [15:0] r_s1_pattern;
    logic [3:0]  r_s1_low;
    logic [3:0]  r_s1_d;
    logic [2:0]  r_s1_class;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_pattern <= '0;
            r_s1_low     <= '0;
            r_s1_d       <= '0;
            r_s1_class   <= c_CLS_ZERO;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_pattern <= in_pattern;
                r_s1_low     <= w_low;
                r_s1_d       <= w_band_d;
                r_s1_class   <= w_class;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: compare against the previous sample
    // ------------------------------------------------------------------
    logic                r_prev_valid;
    logic [2:0]          r_prev_class;
    logic [15:0]         r_prev_pattern;
    logic [3:0]          r_prev_pos;
    logic [c_RUN_W-1:0]  r_run;

    logic               w_same;
    logic               w_changed;
    logic [3:0]         w_pos;
    logic [3:0]         w_prev_inc;
    logic [3:0]         w_prev_dec;
    logic [1:0]         w_motion;
    logic [c_RUN_W-1:0] w_run_next;

    always_comb begin
        w_same     = r_prev_valid && (r_s1_class == r_prev_class);
        w_changed  = r_prev_valid && (r_s1_class != r_prev_class);
        w_prev_inc = r_prev_pos + 4'd1;
        w_prev_dec = r_prev_pos - 4'd1;

        case (r_s1_class)
            c_CLS_SINGLE: w_pos = r_s1_low;
            c_CLS_BAND:   w_pos = r_s1_d;
            default:      w_pos = 4'd0;
        endcase

        w_motion = c_MOT_JUMP;
        if (w_same) begin
            case (r_s1_class)
                // 4-bit wrap makes 15->0 an UP step and 0->15 a DOWN step
                c_CLS_SINGLE, c_CLS_BAND: begin
                    if (w_pos == r_prev_pos) begin
                        w_motion = c_MOT_HOLD;
                    end else if (w_pos == w_prev_inc) begin
                        w_motion = c_MOT_UP;
                    end else if (w_pos == w_prev_dec) begin
                        w_motion = c_MOT_DOWN;
                    end else begin
                        w_motion = c_MOT_JUMP;
                    end
                end
                c_CLS_ALT: begin
                    if (r_s1_pattern == r_prev_pattern) begin
                        w_motion = c_MOT_HOLD;
                    end else if (r_s1_pattern == ~r_prev_pattern) begin
                        w_motion = c_MOT_UP;
                    end else begin
                        w_motion = c_MOT_JUMP;
                    end
                end
                c_CLS_ZERO, c_CLS_FULL: begin
                    w_motion = c_MOT_HOLD;
                end
                default: begin
                    w_motion = (r_s1_pattern == r_prev_pattern) ? c_MOT_HOLD : c_MOT_JUMP;
                end
            endcase
        end

        if (!w_same) begin
            w_run_next = c_RUN_ONE;
        end else if (r_run >= c_STABLE) begin
            w_run_next = c_STABLE;
        end else begin
            w_run_next = r_run + c_RUN_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers: results, history and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_class      <= c_CLS_ZERO;
            out_motion     <= c_MOT_HOLD;
            out_pos        <= '0;
            stable         <= 1'b0;
            change_count   <= '0;
            r_prev_valid   <= 1'b0;
            r_prev_class   <= c_CLS_ZERO;
            r_prev_pattern <= '0;
            r_prev_pos     <= '0;
            r_run          <= '0;
        end else begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_class      <= r_s1_class;
                out_motion     <= w_motion;
                out_pos        <= w_pos;
                stable         <= (w_run_next >= c_STABLE);
                r_run          <= w_run_next;
                r_prev_valid   <= 1'b1;
                r_prev_class   <= r_s1_class;
                r_prev_pattern <= r_s1_pattern;
                r_prev_pos     <= w_pos;
                if (w_changed) begin
                    change_count <= change_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_pattern_classifier
//  Purpose  : Self-checking bench: directed vector table, reset sequence and
//             randomized traffic against a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_pattern_classifier;

    localparam int STABLE_LEN = 4;
    localparam int CNT_W      = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [15:0]      in_pattern;
    logic             out_valid;
    logic [2:0]       out_class;
    logic [1:0]       out_motion;
    logic [3:0]       out_pos;
    logic             stable;
    logic [CNT_W-1:0] change_count;

    led_pattern_classifier #(
        .STABLE_LEN (STABLE_LEN),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_pattern   (in_pattern),
        .out_valid    (out_valid),
        .out_class    (out_class),
        .out_motion   (out_motion),
        .out_pos      (out_pos),
        .stable       (stable),
        .change_count (change_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cls;
        int mot;
        int pos;
        int stb;
        int cc;
    } res_t;

    typedef struct {
        logic [15:0] p;
        int cls;
        int mot;
        int pos;
        int stb;
        int cc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_prev_valid;
    int          m_prev_cls;
    logic [15:0] m_prev_pat;
    int          m_prev_pos;
    int          m_run;
    int          m_cc;
    bit          pend_valid;
    res_t        pend;
    res_t        held;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_band(input int d);
        return 16'((((32'd1 << (2 * d + 2)) - 32'd1) << (7 - d)));
    endfunction

    // Classify and measure one sample straight from the rules; advances model history.
    function automatic res_t model(input logic [15:0] p);
        res_t r;
        int   cls;
        int   pos;
        int   mot;
        bit   same;
        pos = 0;
        if (p == 16'h0000)                        cls = 0;
        else if (p == 16'hFFFF)                   cls = 4;
        else if (p == 16'hAAAA || p == 16'h5555)  cls = 3;
        else if ($countones(p) == 1) begin
            cls = 1;
            pos = $clog2(p);
        end else begin
            cls = 5;
            for (int d = 0; d <= 6; d++) begin
                if (p == ref_band(d)) begin
                    cls = 2;
                    pos = d;
                end
            end
        end
        same = m_prev_valid && (cls == m_prev_cls);
        if (!same)                                  mot = 3;
        else if (cls == 0 || cls == 4)              mot = 0;
        else if (cls == 1) begin
            if (pos == m_prev_pos)                  mot = 0;
            else if (pos == (m_prev_pos + 1) % 16)  mot = 1;
            else if (pos == (m_prev_pos + 15) % 16) mot = 2;
            else                                    mot = 3;
        end else if (cls == 2) begin
            if (pos == m_prev_pos)                  mot = 0;
            else if (pos == m_prev_pos + 1)         mot = 1;
            else if (pos == m_prev_pos - 1)         mot = 2;
            else                                    mot = 3;
        end else if (cls == 3) begin
            if (p == m_prev_pat)                    mot = 0;
            else if (p == ~m_prev_pat)              mot = 1;
            else                                    mot = 3;
        end else begin
            mot = (p == m_prev_pat) ? 0 : 3;
        end
        if (m_prev_valid && !same) m_cc = (m_cc + 1) % (1 << CNT_W);
        m_run        = same ? ((m_run + 1 > STABLE_LEN) ? STABLE_LEN : m_run + 1) : 1;
        m_prev_valid = 1'b1;
        m_prev_cls   = cls;
        m_prev_pat   = p;
        m_prev_pos   = pos;
        r.cls = cls;
        r.mot = mot;
        r.pos = pos;
        r.stb = (m_run >= STABLE_LEN) ? 1 : 0;
        r.cc  = m_cc;
        return r;
    endfunction

    task automatic model_reset();
        m_prev_valid = 1'b0;
        m_prev_cls   = 0;
        m_prev_pat   = '0;
        m_prev_pos   = 0;
        m_run        = 0;
        m_cc         = 0;
        pend_valid   = 1'b0;
        held         = '{0, 0, 0, 0, 0};
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid"},  int'(out_valid),    0);
        chk({tag, ".class"},  int'(out_class),    0);
        chk({tag, ".motion"}, int'(out_motion),   0);
        chk({tag, ".pos"},    int'(out_pos),      0);
        chk({tag, ".stable"}, int'(stable),       0);
        chk({tag, ".cc"},     int'(change_count), 0);
    endtask

    // One clock: drive inputs, check the outputs due this cycle, advance the model.
    task automatic tick(input logic v, input logic [15:0] p);
        in_valid   = v;
        in_pattern = p;
        @(posedge clk);
        #1;
        chk("out_valid", int'(out_valid), int'(pend_valid));
        if (pend_valid) held = pend;
        chk("class",  int'(out_class),    held.cls);
        chk("motion", int'(out_motion),   held.mot);
        chk("pos",    int'(out_pos),      held.pos);
        chk("stable", int'(stable),       held.stb);
        chk("cc",     int'(change_count), held.cc);
        pend_valid = v;
        if (v) pend = model(p);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_zero("reset");
        #2;
        rst = 1'b0;
    endtask

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    logic [15:0] pat;
    int          walk;
    int          kind;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        //            pattern   cls mot pos stb cc
        vecs[0]  = '{16'h0001, 1, 3, 0,  0, 0};
        vecs[1]  = '{16'h0002, 1, 1, 1,  0, 0};
        vecs[2]  = '{16'h0004, 1, 1, 2,  0, 0};
        vecs[3]  = '{16'h8000, 1, 3, 15, 1, 0};
        vecs[4]  = '{16'h0001, 1, 1, 0,  1, 0};
        vecs[5]  = '{16'h8000, 1, 2, 15, 1, 0};
        vecs[6]  = '{16'h0180, 2, 3, 0,  0, 1};
        vecs[7]  = '{16'h03C0, 2, 1, 1,  0, 1};
        vecs[8]  = '{16'h07E0, 2, 1, 2,  0, 1};
        vecs[9]  = '{16'hFFFF, 4, 3, 0,  0, 2};
        vecs[10] = '{16'hAAAA, 3, 3, 0,  0, 3};
        vecs[11] = '{16'h5555, 3, 1, 0,  0, 3};
        vecs[12] = '{16'h5555, 3, 0, 0,  0, 3};
        vecs[13] = '{16'hAAAA, 3, 1, 0,  1, 3};
        vecs[14] = '{16'hACE1, 5, 3, 0,  0, 4};
        vecs[15] = '{16'hACE1, 5, 0, 0,  0, 4};
        vecs[16] = '{16'h0000, 0, 3, 0,  0, 5};
        vecs[17] = '{16'h0000, 0, 0, 0,  0, 5};

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_pattern = '0;
        model_reset();
        #1;
        check_zero("async_reset");
        do_reset();

        // Directed table, back-to-back; result of entry i-1 is due after tick i.
        for (int i = 0; i <= NVEC; i++) begin
            if (i < NVEC) tick(1'b1, vecs[i].p);
            else          tick(1'b0, 16'h0000);
            if (i > 0) begin
                chk("vec.valid",  int'(out_valid),    1);
                chk("vec.class",  int'(out_class),    vecs[i-1].cls);
                chk("vec.motion", int'(out_motion),   vecs[i-1].mot);
                chk("vec.pos",    int'(out_pos),      vecs[i-1].pos);
                chk("vec.stable", int'(stable),       vecs[i-1].stb);
                chk("vec.cc",     int'(change_count), vecs[i-1].cc);
            end
        end
        tick(1'b0, 16'h0000);

        // Idle gaps must not disturb motion: single walking up across gaps.
        tick(1'b1, 16'h0010);
        tick(1'b0, 16'h0000);
        tick(1'b0, 16'h0000);
        tick(1'b1, 16'h0020);
        tick(1'b0, 16'h0000);
        chk("gap.motion", int'(out_motion), 1);
        tick(1'b0, 16'h0000);

        // Reset with samples in flight: outputs clear at once, nothing emerges.
        tick(1'b1, 16'h0001);
        tick(1'b1, 16'h0002);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check_zero("midrst_async");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("midrst_clk");
        rst = 1'b0;
        tick(1'b0, 16'h0000);
        tick(1'b1, 16'h0004);
        tick(1'b0, 16'h0000);
        chk("postrst.valid",  int'(out_valid),    1);
        chk("postrst.motion", int'(out_motion),   3);
        chk("postrst.cc",     int'(change_count), 0);

        // Randomized traffic mixing every shape class.
        walk = 0;
        for (int n = 0; n < 3000; n++) begin
            kind = int'($urandom_range(0, 9));
            case (kind)
                0: pat = 16'h0000;
                1: pat = 16'hFFFF;
                2: pat = ($urandom_range(0, 1) != 0) ? 16'hAAAA : 16'h5555;
                3: pat = 16'(32'd1 << $urandom_range(0, 15));
                4, 5: begin
                    walk = (walk + int'($urandom_range(0, 2)) + 15) % 16;
                    pat  = 16'(32'd1 << walk);
                end
                6, 7: pat = ref_band(int'($urandom_range(0, 6)));
                default: pat = 16'($urandom);
            endcase
            tick($urandom_range(0, 3) != 0, pat);
            if (n == 1500) do_reset();
        end
        tick(1'b0, 16'h0000);
        tick(1'b0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
